// File: rtl/mac_pkg.sv
// Shared width helpers and the saturation clamp for the streaming MAC engine.
package mac_pkg;

  // Widest accumulator the generic clamp can handle.
  localparam int MAX_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

  // Full-precision width of one lane product.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Width that holds the sum of all lane products plus the carry-in bit.
  function automatic int sum_w(input int a_w, input int b_w, input int lanes);
    return prod_w(a_w, b_w) + clog2(lanes) + 1;
  endfunction

  // Replace an overflowed w-bit result with the bound in the overflow direction.
  // neg selects the negative bound for two's-complement overflow.
  function automatic logic [MAX_W-1:0] sat_clamp(input logic [MAX_W-1:0] raw,
                                                 input logic             ovf,
                                                 input logic             neg,
                                                 input logic             signd,
                                                 input int               w);
    logic [MAX_W-1:0] ones;
    ones = (MAX_W'(1) << w) - MAX_W'(1);
    if (!ovf) return raw;
    else if (!signd) return ones;
    else if (neg) return MAX_W'(1) << (w - 1);
    else return ones >> 1;
  endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// One registered A_W x B_W multiplier lane; the register only loads on enable.
module mac_lane_mul
  import mac_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int SIGNED = 0
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic [A_W-1:0]             a_i,
  input  logic [B_W-1:0]             b_i,
  output logic [prod_w(A_W,B_W)-1:0] p_o
);

  localparam int PW = prod_w(A_W, B_W);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic        [PW-1:0] prod_d;
  logic        [PW-1:0] prod_q;

  // Extend both operands to product width so the low PW bits are exact either way.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{B_W{a_i[A_W-1]}}, a_i};
      b_ext = {{A_W{b_i[B_W-1]}}, b_i};
    end else begin
      a_ext = {{B_W{1'b0}}, a_i};
      b_ext = {{A_W{1'b0}}, b_i};
    end
    prod_d = a_ext * b_ext;
  end

  // Product register (data only, no reset).
  always_ff @(posedge clk_i) begin
    if (en_i) prod_q <= prod_d;
  end

  assign p_o = prod_q;

endmodule

// File: rtl/mac_stream_acc.sv
// Multi-lane streaming multiply-accumulate: one result per IN_LAST-delimited frame.
module mac_stream_acc
  import mac_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CE,
  input  logic                 CLR,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 IN_LAST,
  input  logic [LANES*A_W-1:0] A,
  input  logic [LANES*B_W-1:0] B,
  input  logic                 CARRYIN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ACC_W-1:0]     P_OUT,
  output logic                 OVF,
  output logic [CNT_W-1:0]     CNT_OUT
);

  localparam int PW    = prod_w(A_W, B_W);
  localparam int SUM_W = sum_w(A_W, B_W, LANES);

  logic stall, adv, accept;

  logic first_q;
  logic vld_p1_q, last_p1_q, first_p1_q, cin_p1_q;
  logic [PW-1:0] prod_p1 [LANES];

  logic [SUM_W-1:0] lane_sum;
  logic [ACC_W-1:0] sum_p2_d, sum_p2_q;
  logic vld_p2_q, last_p2_q, first_p2_q;

  logic             add_c, add_ovf;
  logic [ACC_W-1:0] add_raw;
  logic [MAX_W-1:0] sat_full;
  logic             unused_sat_hi;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_d, ovf_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             vld_p3_q, last_p3_q;

  logic             out_vld_q, ovf_out_q;
  logic [ACC_W-1:0] p_out_q;
  logic [CNT_W-1:0] cnt_out_q;

  // A held result blocks the whole pipeline; CE freezes everything.
  assign stall    = out_vld_q & ~OUT_READY;
  assign adv      = CE & ~stall;
  assign IN_READY = adv & ~CLR;
  assign accept   = IN_VALID & IN_READY;

  // ---- S1: lane products ----
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane_mul #(.A_W(A_W), .B_W(B_W), .SIGNED(SIGNED)) u_mul (
      .clk_i (CLK),
      .en_i  (accept),
      .a_i   (A[g*A_W +: A_W]),
      .b_i   (B[g*B_W +: B_W]),
      .p_o   (prod_p1[g])
    );
  end

  // S1 control: beat valid/last, frame-start flag and carry-in qualified by it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_q    <= 1'b1;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      first_p1_q <= 1'b0;
      cin_p1_q   <= 1'b0;
    end else if (CLR) begin
      first_q    <= 1'b1;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      first_p1_q <= 1'b0;
      cin_p1_q   <= 1'b0;
    end else if (adv) begin
      vld_p1_q   <= accept;
      last_p1_q  <= IN_LAST;
      first_p1_q <= first_q;
      cin_p1_q   <= CARRYIN & first_q;
      if (accept) first_q <= IN_LAST;
    end
  end

  // ---- S2: lane sum plus carry-in ----
  // Sum the extended products at full sum width, then extend to the accumulator.
  always_comb begin
    lane_sum = SUM_W'(cin_p1_q);
    for (int i = 0; i < LANES; i++) begin
      if (SIGNED != 0) lane_sum = lane_sum + {{(SUM_W-PW){prod_p1[i][PW-1]}}, prod_p1[i]};
      else             lane_sum = lane_sum + {{(SUM_W-PW){1'b0}}, prod_p1[i]};
    end
    if (SIGNED != 0) sum_p2_d = ACC_W'($signed(lane_sum));
    else             sum_p2_d = ACC_W'(lane_sum);
  end

  // S2 data register.
  always_ff @(posedge CLK) begin
    if (adv) sum_p2_q <= sum_p2_d;
  end

  // S2 control register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      first_p2_q <= 1'b0;
    end else if (CLR) begin
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      first_p2_q <= 1'b0;
    end else if (adv) begin
      vld_p2_q   <= vld_p1_q;
      last_p2_q  <= last_p1_q;
      first_p2_q <= first_p1_q;
    end
  end

  // ---- S3: accumulate ----
  // Add with overflow detection; a saturated sum is held until the frame ends.
  always_comb begin
    {add_c, add_raw} = {1'b0, acc_q} + {1'b0, sum_p2_q};
    if (SIGNED != 0)
      add_ovf = (acc_q[ACC_W-1] == sum_p2_q[ACC_W-1]) && (add_raw[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = add_c;
    sat_full = sat_clamp(MAX_W'(add_raw), add_ovf, acc_q[ACC_W-1], (SIGNED != 0), ACC_W);
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (vld_p2_q) begin
      if (first_p2_q) begin
        acc_d = sum_p2_q;
        ovf_d = 1'b0;
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
        if (SAT != 0) begin
          if (!ovf_q) acc_d = sat_full[ACC_W-1:0];
        end else begin
          acc_d = add_raw;
        end
      end
    end
  end

  // Upper bits of the generic clamp result are intentionally dropped.
  assign unused_sat_hi = ^sat_full[MAX_W-1:ACC_W];

  // Accumulator, sticky overflow and beat counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      vld_p3_q  <= 1'b0;
      last_p3_q <= 1'b0;
    end else if (CLR) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      vld_p3_q  <= 1'b0;
      last_p3_q <= 1'b0;
    end else if (adv) begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      vld_p3_q  <= vld_p2_q;
      last_p3_q <= last_p2_q;
    end
  end

  // ---- Output register ----
  // Frame close loads the result; otherwise an unstalled cycle means it was popped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_vld_q <= 1'b0;
      p_out_q   <= '0;
      ovf_out_q <= 1'b0;
      cnt_out_q <= '0;
    end else if (CLR) begin
      out_vld_q <= 1'b0;
      p_out_q   <= '0;
      ovf_out_q <= 1'b0;
      cnt_out_q <= '0;
    end else if (adv) begin
      if (vld_p3_q && last_p3_q) begin
        out_vld_q <= 1'b1;
        p_out_q   <= acc_q;
        ovf_out_q <= ovf_q;
        cnt_out_q <= cnt_q;
      end else begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign OUT_VALID = out_vld_q;
  assign P_OUT     = p_out_q;
  assign OVF       = ovf_out_q;
  assign CNT_OUT   = cnt_out_q;

endmodule

// File: tb/tb_mac_stream_acc.sv
// Scoreboard bench for mac_stream_acc across four parameterisations sharing one stimulus bus.
module tb_mac_stream_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0, ce = 1'b0, clr = 1'b0;
  logic vld_s = 1'b0, last_s = 1'b0, cin_s = 1'b0, out_ready = 1'b1;
  logic [63:0] a_s = '0, b_s = '0;
  int sel = 0;

  always #5 clk = ~clk;

  logic [3:0] ivld, rdy, ov, ovf;
  logic [32:0] pA, pB, pD;
  logic [39:0] pC;
  logic [15:0] cA, cB, cC, cD;
  logic [39:0] pout [4];
  logic [15:0] cnt  [4];

  assign ivld = {4{vld_s}} & {sel == 3, sel == 2, sel == 1, sel == 0};
  assign pout[0] = {7'd0, pA};
  assign pout[1] = {7'd0, pB};
  assign pout[2] = pC;
  assign pout[3] = {7'd0, pD};
  assign cnt[0] = cA;
  assign cnt[1] = cB;
  assign cnt[2] = cC;
  assign cnt[3] = cD;

  // dut0: 1 lane, unsigned, 33-bit saturating
  mac_stream_acc #(.A_W(16), .B_W(16), .LANES(1), .ACC_W(33), .CNT_W(16), .SIGNED(0), .SAT(1)) d0 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .IN_VALID(ivld[0]), .IN_READY(rdy[0]),
    .IN_LAST(last_s), .A(a_s[15:0]), .B(b_s[15:0]), .CARRYIN(cin_s), .OUT_VALID(ov[0]),
    .OUT_READY(out_ready), .P_OUT(pA), .OVF(ovf[0]), .CNT_OUT(cA));
  // dut1: 1 lane, unsigned, 33-bit wrapping
  mac_stream_acc #(.A_W(16), .B_W(16), .LANES(1), .ACC_W(33), .CNT_W(16), .SIGNED(0), .SAT(0)) d1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .IN_VALID(ivld[1]), .IN_READY(rdy[1]),
    .IN_LAST(last_s), .A(a_s[15:0]), .B(b_s[15:0]), .CARRYIN(cin_s), .OUT_VALID(ov[1]),
    .OUT_READY(out_ready), .P_OUT(pB), .OVF(ovf[1]), .CNT_OUT(cB));
  // dut2: 4 lanes, unsigned, 40-bit saturating
  mac_stream_acc #(.A_W(16), .B_W(16), .LANES(4), .ACC_W(40), .CNT_W(16), .SIGNED(0), .SAT(1)) d2 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .IN_VALID(ivld[2]), .IN_READY(rdy[2]),
    .IN_LAST(last_s), .A(a_s), .B(b_s), .CARRYIN(cin_s), .OUT_VALID(ov[2]),
    .OUT_READY(out_ready), .P_OUT(pC), .OVF(ovf[2]), .CNT_OUT(cC));
  // dut3: 1 lane, signed, 33-bit saturating
  mac_stream_acc #(.A_W(16), .B_W(16), .LANES(1), .ACC_W(33), .CNT_W(16), .SIGNED(1), .SAT(1)) d3 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .CLR(clr), .IN_VALID(ivld[3]), .IN_READY(rdy[3]),
    .IN_LAST(last_s), .A(a_s[15:0]), .B(b_s[15:0]), .CARRYIN(cin_s), .OUT_VALID(ov[3]),
    .OUT_READY(out_ready), .P_OUT(pD), .OVF(ovf[3]), .CNT_OUT(cD));

  typedef struct {
    int          d;
    logic [39:0] p;
    logic        o;
    logic [15:0] c;
  } exp_t;
  exp_t sb[$];

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic expect_res(input int d, input logic [39:0] p, input logic o, input logic [15:0] c);
    exp_t e;
    e.d = d; e.p = p; e.o = o; e.c = c;
    sb.push_back(e);
  endtask

  // Present one beat to dut d and return just after the edge that accepts it.
  task automatic beat(input int d, input logic [63:0] a, input logic [63:0] b,
                      input logic last, input logic cin);
    int n;
    sel = d; a_s = a; b_s = b; last_s = last; cin_s = cin; vld_s = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL accept_timeout dut%0d: waited %0d cycles, limit 200", d, n);
    end
    @(posedge clk);
    #1;
    vld_s = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output handshake pops and checks the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ce && out_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (ov[k]) begin
            if (sb.size() == 0) begin
              total++;
              $display("FAIL unexpected_result dut%0d: P_OUT=%0h with nothing expected", k, pout[k]);
            end else begin
              e = sb.pop_front();
              chk("result_dut", k, e.d);
              chk("p_out", pout[k], e.p);
              chk("ovf", ovf[k], e.o);
              chk("cnt_out", cnt[k], e.c);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ce = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_out_valid", ov[k], 0);
      chk("rst_p_out", pout[k], 0);
      chk("rst_ovf", ovf[k], 0);
      chk("rst_cnt", cnt[k], 0);
      chk("rst_in_ready", rdy[k], 1);
    end
    @(posedge clk);
    #1;

    // Single lane frame, result 10+20+30+0, three cycles after LAST
    expect_res(0, 40'd60, 1'b0, 16'd4);
    beat(0, 64'd1, 64'd10, 1'b0, 1'b0);
    beat(0, 64'd2, 64'd10, 1'b0, 1'b0);
    beat(0, 64'd3, 64'd10, 1'b0, 1'b0);
    beat(0, 64'd4, 64'd0, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ov[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("last_to_valid_latency", n, 3);
    drain();

    // Four lanes, back-to-back one-beat frames: 5+12+21+32 (+1 carry-in)
    expect_res(2, 40'd71, 1'b0, 16'd1);
    expect_res(2, 40'd70, 1'b0, 16'd1);
    beat(2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 1'b1, 1'b1);
    beat(2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 1'b1, 1'b0);
    drain();

    // Output held for 10 cycles while more beats queue up behind it
    out_ready = 1'b0;
    expect_res(0, 40'd25, 1'b0, 16'd1);
    expect_res(0, 40'd14, 1'b0, 16'd3);
    fork
      begin
        beat(0, 64'd5, 64'd5, 1'b1, 1'b0);
        beat(0, 64'd1, 64'd1, 1'b0, 1'b0);
        beat(0, 64'd2, 64'd2, 1'b0, 1'b0);
        beat(0, 64'd3, 64'd3, 1'b1, 1'b0);
      end
      begin
        int w;
        w = 0;
        while (!ov[0] && w < 50) begin
          @(negedge clk);
          w++;
        end
        repeat (10) begin
          @(negedge clk);
          chk("stall_in_ready", rdy[0], 0);
          chk("stall_p_out", pout[0], 25);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Three beats of 0xFFFF*0xFFFF: saturating clamps, wrapping wraps
    expect_res(0, 40'h1_FFFF_FFFF, 1'b1, 16'd3);
    beat(0, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0);
    beat(0, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0);
    beat(0, 64'hFFFF, 64'hFFFF, 1'b1, 1'b0);
    drain();
    expect_res(1, 40'h0_FFFA_0003, 1'b1, 16'd3);
    beat(1, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0);
    beat(1, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0);
    beat(1, 64'hFFFF, 64'hFFFF, 1'b1, 1'b0);
    drain();

    // Signed: -3*7 + 2*-5 = -31 as 33-bit two's complement
    expect_res(3, 40'h1_FFFF_FFE1, 1'b0, 16'd2);
    beat(3, 64'hFFFD, 64'd7, 1'b0, 1'b0);
    beat(3, 64'd2, 64'hFFFB, 1'b1, 1'b0);
    drain();

    // Clear discards a partial frame; only the following frame produces a result
    beat(0, 64'd9, 64'd9, 1'b0, 1'b0);
    beat(0, 64'd8, 64'd8, 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", rdy[0], 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    expect_res(0, 40'd42, 1'b0, 16'd1);
    beat(0, 64'd6, 64'd7, 1'b1, 1'b0);
    drain();

    // Clock-enable gap mid-frame gives the same result as the uninterrupted frame
    expect_res(0, 40'd60, 1'b0, 16'd4);
    beat(0, 64'd1, 64'd10, 1'b0, 1'b0);
    beat(0, 64'd2, 64'd10, 1'b0, 1'b0);
    ce = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("ce_low_in_ready", rdy[0], 0);
    end
    @(posedge clk);
    #1;
    ce = 1'b1;
    beat(0, 64'd3, 64'd10, 1'b0, 1'b0);
    beat(0, 64'd4, 64'd0, 1'b1, 1'b0);
    drain();

    repeat (10) @(posedge clk);
    chk("scoreboard_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
